// File: rtl/dram_ctrl_pkg.sv
// Shared configuration for the data-RAM access controller: RAM depth,
// access-size encoding and byte-lane mask helpers.
package dram_ctrl_pkg;

    localparam int dram_depth = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    function automatic logic [3:0] mask(input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: mask = 4'b0001;
            SIZE_HALF: mask = 4'b0011;
            default:   mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] data_mask(input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: data_mask = 32'h0000_00FF;
            SIZE_HALF: data_mask = 32'h0000_FFFF;
            default:   data_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Core request/response bus plus word-addressed RAM port of the controller.
interface dram_ctrl_if
    import dram_ctrl_pkg::*;
;
    logic                  mem_valid;
    logic                  mem_wen;
    logic [1:0]            mem_size;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic                  mem_error;
    logic                  dram_wen;
    logic [dram_depth-1:0] dram_waddr;
    logic [dram_depth-1:0] dram_raddr;
    logic [31:0]           dram_wdata;
    logic [3:0]            dram_wstrb;
    logic [31:0]           dram_rdata;

    modport slave (
        input  mem_valid, mem_wen, mem_size, mem_addr, mem_wdata, dram_rdata,
        output mem_ready, mem_rdata, mem_error,
        output dram_wen, dram_waddr, dram_raddr, dram_wdata, dram_wstrb
    );

    modport master (
        output mem_valid, mem_wen, mem_size, mem_addr, mem_wdata, dram_rdata,
        input  mem_ready, mem_rdata, mem_error,
        input  dram_wen, dram_waddr, dram_raddr, dram_wdata, dram_wstrb
    );

endinterface

// File: rtl/dram_ctrl.sv
// Converts byte-addressed core loads/stores into word-addressed, byte-strobed
// RAM cycles, splitting word-crossing accesses into two RAM cycles.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter logic [31:0] dram_base = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dram_ctrl_if.slave    bus
);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_SECOND = 1'b1;

    logic [0:0]            state_reg;
    logic                  ready_reg;
    logic                  error_reg;
    logic                  load_reg;
    logic                  split_reg;
    logic                  store_reg;
    logic [1:0]            off_reg;
    logic [1:0]            size_reg;
    logic [dram_depth-1:0] waddr2_reg;
    logic [31:0]           hi_data_reg;
    logic [3:0]            hi_strb_reg;
    logic [31:0]           low_reg;

    // Request decode
    logic [dram_depth-1:0] word_idx;
    logic [1:0]            off;
    logic [2:0]            span;
    logic                  split;
    logic                  req_err;
    logic                  accept;
    logic [7:0]            strb_wide;
    logic [63:0]           data_wide;

    assign word_idx  = bus.mem_addr[dram_depth+1:2];
    assign off       = bus.mem_addr[1:0];
    assign span      = {1'b0, off} + size_bytes(bus.mem_size);
    assign split     = span > 3'd4;
    assign req_err   = (bus.mem_addr[31:dram_depth+2] != dram_base[31:dram_depth+2])
                     || (bus.mem_size == 2'd3)
                     || (split && (&word_idx));
    assign accept    = (state_reg == STATE_IDLE) && bus.mem_valid && !reset;
    // The upper halves of these shifted values are exactly what the second
    // cycle of a split store needs: mask>>(4-o) and wdata>>8(4-o).
    assign strb_wide = {4'b0000, mask(bus.mem_size)} << off;
    assign data_wide = {32'h0, bus.mem_wdata} << {off, 3'b000};

    always_comb begin
        bus.dram_wen   = 1'b0;
        bus.dram_wstrb = 4'b0000;
        bus.dram_waddr = word_idx;
        bus.dram_raddr = word_idx;
        bus.dram_wdata = data_wide[31:0];
        if (state_reg == STATE_SECOND) begin
            bus.dram_waddr = waddr2_reg;
            bus.dram_raddr = waddr2_reg;
            bus.dram_wdata = hi_data_reg;
            if (store_reg && !reset) begin
                bus.dram_wen   = 1'b1;
                bus.dram_wstrb = hi_strb_reg;
            end
        end else if (accept && bus.mem_wen && !req_err) begin
            bus.dram_wen   = 1'b1;
            bus.dram_wstrb = strb_wide[3:0];
        end
    end

    // Response datapath
    logic [31:0] aligned_low;
    logic [2:0]  hi_shift;
    logic [31:0] merged;
    logic [31:0] rdata_raw;

    assign aligned_low = bus.dram_rdata >> {off_reg, 3'b000};
    assign hi_shift    = 3'd4 - {1'b0, off_reg};
    assign merged      = low_reg | (bus.dram_rdata << {hi_shift, 3'b000});
    assign rdata_raw   = split_reg ? merged : aligned_low;

    assign bus.mem_ready = ready_reg && !reset;
    assign bus.mem_error = error_reg && !reset;
    assign bus.mem_rdata = (ready_reg && load_reg && !reset)
                         ? (rdata_raw & data_mask(size_reg)) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= STATE_IDLE;
            ready_reg   <= 1'b0;
            error_reg   <= 1'b0;
            load_reg    <= 1'b0;
            split_reg   <= 1'b0;
            store_reg   <= 1'b0;
            off_reg     <= 2'd0;
            size_reg    <= 2'd0;
            waddr2_reg  <= '0;
            hi_data_reg <= 32'h0;
            hi_strb_reg <= 4'b0000;
            low_reg     <= 32'h0;
        end else begin
            ready_reg <= 1'b0;
            error_reg <= 1'b0;
            load_reg  <= 1'b0;
            split_reg <= 1'b0;
            case (state_reg)
                STATE_IDLE: begin
                    if (bus.mem_valid) begin
                        off_reg     <= off;
                        size_reg    <= bus.mem_size;
                        store_reg   <= bus.mem_wen;
                        waddr2_reg  <= word_idx + 1'b1;
                        hi_data_reg <= data_wide[63:32];
                        hi_strb_reg <= strb_wide[7:4];
                        if (req_err) begin
                            ready_reg <= 1'b1;
                            error_reg <= 1'b1;
                        end else if (split) begin
                            state_reg <= STATE_SECOND;
                        end else begin
                            ready_reg <= 1'b1;
                            load_reg  <= !bus.mem_wen;
                        end
                    end
                end
                default: begin
                    // Low bytes of a split load arrive now; the upper word is read this cycle.
                    low_reg   <= aligned_low;
                    ready_reg <= 1'b1;
                    load_reg  <= !store_reg;
                    split_reg <= 1'b1;
                    state_reg <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a behavioural byte-strobed RAM whose
// reset contents put byte value (addr & 0xFF) at every byte address.
module tb_dram_ctrl;
    import dram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_ctrl_if bus();

    dram_ctrl #(.dram_base(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] ram [256];
    logic [31:0] ram_q;
    logic        ram_init = 1'b1;

    assign bus.dram_rdata = ram_q;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] a;
        a = 8'(4 * i);
        return {a + 8'd3, a + 8'd2, a + 8'd1, a};
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.dram_wen && bus.dram_wstrb[b])
                    ram[bus.dram_waddr][8*b +: 8] <= bus.dram_wdata[8*b +: 8];
        end
        ram_q <= ram[bus.dram_raddr];
    end

    always @(posedge clk)
        if (!reset)
            assert (!(dut.state_reg == 1'b1 && bus.mem_valid))
                else $error("protocol violation: mem_valid while split access pending");

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wen, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_valid = 1'b1;
        bus.mem_wen   = wen;
        bus.mem_size  = size;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.mem_wen   = 1'b0;
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;

        repeat (3) tick();
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_error", 32'(bus.mem_error), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_wen",   32'(bus.dram_wen), 32'd0);
        check("rst_wstrb", 32'(bus.dram_wstrb), 32'd0);
        ram_init = 1'b0;
        reset    = 1'b0;
        tick();

        // Aligned word store then load issued in the store's ready cycle
        req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        #1;
        check("sw_wen",   32'(bus.dram_wen), 32'd1);
        check("sw_waddr", 32'(bus.dram_waddr), 32'd4);
        check("sw_wstrb", 32'(bus.dram_wstrb), 32'hF);
        check("sw_wdata", bus.dram_wdata, 32'hDEADBEEF);
        tick();
        check("sw_ready", 32'(bus.mem_ready), 32'd1);
        check("sw_error", 32'(bus.mem_error), 32'd0);
        check("sw_rdata", bus.mem_rdata, 32'h0);
        req(1'b0, 2'd2, 32'h10, 32'h0);
        #1;
        check("lw_raddr", 32'(bus.dram_raddr), 32'd4);
        check("lw_wen",   32'(bus.dram_wen), 32'd0);
        tick();
        idle();
        check("lw_ready", 32'(bus.mem_ready), 32'd1);
        check("lw_error", 32'(bus.mem_error), 32'd0);
        check("lw_rdata", bus.mem_rdata, 32'hDEADBEEF);
        $display("txn word store/load @0x10 done");

        // Byte store at offset 3, half load at offset 2
        req(1'b1, 2'd0, 32'h13, 32'h123456AB);
        #1;
        check("sb_wstrb", 32'(bus.dram_wstrb), 32'h8);
        check("sb_wdata", bus.dram_wdata, 32'hAB000000);
        check("sb_waddr", 32'(bus.dram_waddr), 32'd4);
        tick();
        check("sb_ready", 32'(bus.mem_ready), 32'd1);
        req(1'b0, 2'd1, 32'h12, 32'h0);
        tick();
        idle();
        check("lh_ready", 32'(bus.mem_ready), 32'd1);
        check("lh_rdata", bus.mem_rdata, 32'h0000ABAD);
        $display("txn byte store @0x13 / half load @0x12 done");

        // Split word store across words 3/4, then split loads
        req(1'b1, 2'd2, 32'h0E, 32'h11223344);
        #1;
        check("ss1_wen",   32'(bus.dram_wen), 32'd1);
        check("ss1_waddr", 32'(bus.dram_waddr), 32'd3);
        check("ss1_wstrb", 32'(bus.dram_wstrb), 32'hC);
        check("ss1_wdata", bus.dram_wdata, 32'h33440000);
        tick();
        idle();
        #1;
        check("ss2_ready", 32'(bus.mem_ready), 32'd0);
        check("ss2_wen",   32'(bus.dram_wen), 32'd1);
        check("ss2_waddr", 32'(bus.dram_waddr), 32'd4);
        check("ss2_wstrb", 32'(bus.dram_wstrb), 32'h3);
        check("ss2_wdata", bus.dram_wdata, 32'h00001122);
        tick();
        check("ss_ready", 32'(bus.mem_ready), 32'd1);
        check("ss_error", 32'(bus.mem_error), 32'd0);
        req(1'b0, 2'd2, 32'h0E, 32'h0);
        #1;
        check("sl1_raddr", 32'(bus.dram_raddr), 32'd3);
        check("sl1_wen",   32'(bus.dram_wen), 32'd0);
        tick();
        idle();
        #1;
        check("sl2_ready", 32'(bus.mem_ready), 32'd0);
        check("sl2_raddr", 32'(bus.dram_raddr), 32'd4);
        check("sl2_wen",   32'(bus.dram_wen), 32'd0);
        tick();
        check("sl_ready", 32'(bus.mem_ready), 32'd1);
        check("sl_rdata", bus.mem_rdata, 32'h11223344);
        req(1'b0, 2'd1, 32'h0F, 32'h0);
        tick();
        idle();
        check("slh2_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        check("slh_ready", 32'(bus.mem_ready), 32'd1);
        check("slh_rdata", bus.mem_rdata, 32'h00002233);
        $display("txn split store/load @0x0E and split half @0x0F done");

        // Error responses
        tick();
        req(1'b1, 2'd2, 32'h400, 32'h55555555);
        #1;
        check("eo_wen", 32'(bus.dram_wen), 32'd0);
        tick();
        idle();
        check("eo_ready", 32'(bus.mem_ready), 32'd1);
        check("eo_error", 32'(bus.mem_error), 32'd1);
        check("eo_rdata", bus.mem_rdata, 32'h0);
        tick();
        check("eo_ready_drop", 32'(bus.mem_ready), 32'd0);
        check("eo_error_drop", 32'(bus.mem_error), 32'd0);
        req(1'b0, 2'd3, 32'h20, 32'h0);
        tick();
        idle();
        check("es_ready", 32'(bus.mem_ready), 32'd1);
        check("es_error", 32'(bus.mem_error), 32'd1);
        check("es_rdata", bus.mem_rdata, 32'h0);
        req(1'b1, 2'd2, 32'h3FD, 32'h66666666);
        #1;
        check("el_wen", 32'(bus.dram_wen), 32'd0);
        tick();
        idle();
        check("el_ready", 32'(bus.mem_ready), 32'd1);
        check("el_error", 32'(bus.mem_error), 32'd1);
        req(1'b0, 2'd2, 32'h3FC, 32'h0);
        tick();
        idle();
        check("lastw_ready", 32'(bus.mem_ready), 32'd1);
        check("lastw_error", 32'(bus.mem_error), 32'd0);
        check("lastw_rdata", bus.mem_rdata, 32'hFFFEFDFC);
        $display("txn error cases (window, size=3, split at last word) done");

        // Back-to-back aligned loads
        for (int k = 0; k < 8; k++) begin
            req(1'b0, 2'd2, 32'h40 + 32'(4 * k), 32'h0);
            tick();
            check($sformatf("b2b%0d_ready", k), 32'(bus.mem_ready), 32'd1);
            check($sformatf("b2b%0d_rdata", k), bus.mem_rdata, init_word(16 + k));
        end
        idle();
        tick();
        check("b2b_ready_drop", 32'(bus.mem_ready), 32'd0);
        $display("txn 8 back-to-back word loads @0x40 done");

        // Reset during the second cycle of a split store
        req(1'b1, 2'd2, 32'h26, 32'hCAFEF00D);
        #1;
        check("rs1_wen",   32'(bus.dram_wen), 32'd1);
        check("rs1_waddr", 32'(bus.dram_waddr), 32'd9);
        check("rs1_wstrb", 32'(bus.dram_wstrb), 32'hC);
        check("rs1_wdata", bus.dram_wdata, 32'hF00D0000);
        tick();
        idle();
        reset = 1'b1;
        #1;
        check("rs2_wen",   32'(bus.dram_wen), 32'd0);
        check("rs2_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        check("rs3_ready", 32'(bus.mem_ready), 32'd0);
        check("rs3_wen",   32'(bus.dram_wen), 32'd0);
        reset = 1'b0;
        tick();
        check("rs4_ready", 32'(bus.mem_ready), 32'd0);
        req(1'b0, 2'd2, 32'h28, 32'h0);
        tick();
        idle();
        check("rs_w10_ready", 32'(bus.mem_ready), 32'd1);
        check("rs_w10_rdata", bus.mem_rdata, 32'h2B2A2928);
        req(1'b0, 2'd2, 32'h24, 32'h0);
        tick();
        idle();
        check("rs_w9_rdata", bus.mem_rdata, 32'hF00D2524);
        $display("txn reset in split store second cycle done");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
